// File: rtl/gemm_kernel_flow_ctrl_if.sv
// Request, fence, response and status signals between the kernel-side CDC FIFOs, the gemm core and the flow controller.
// The master side drives requests and gemm status; the slave side is the flow controller.
interface gemm_kernel_flow_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 8,
    parameter int RSP_W  = 257
);
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH-1:0]        ch_ready;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        iss_en;
    logic [NUM_CH*DATA_W-1:0] iss_data;
    logic                     start_valid;
    logic                     start_ready;
    logic [NUM_CH*CNT_W-1:0]  start_cnt;
    logic                     start_out;
    logic                     gemm_busy;
    logic                     gemm_next_block;
    logic                     rsp_in_valid;
    logic [RSP_W-1:0]         rsp_in_data;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [RSP_W-1:0]         rsp_data;
    logic                     rsp_almost_full;
    logic                     rsp_overflow;
    logic                     done_pulse;
    logic                     next_block_pulse;

    modport master (
        output ch_valid, ch_data, start_valid, start_cnt, gemm_busy, gemm_next_block,
               rsp_in_valid, rsp_in_data, rsp_ready,
        input  ch_ready, iss_en, iss_data, start_ready, start_out, rsp_valid, rsp_data,
               rsp_almost_full, rsp_overflow, done_pulse, next_block_pulse
    );

    modport slave (
        input  ch_valid, ch_data, start_valid, start_cnt, gemm_busy, gemm_next_block,
               rsp_in_valid, rsp_in_data, rsp_ready,
        output ch_ready, iss_en, iss_data, start_ready, start_out, rsp_valid, rsp_data,
               rsp_almost_full, rsp_overflow, done_pulse, next_block_pulse
    );
endinterface

// File: rtl/gemm_kernel_flow_ctrl.sv
// Kernel-side flow control: registered per-channel issue (latency 1), count-based start fence and FWFT response FIFO.
// Channels that finished their batch are held off until start fires; responses cannot be stalled and overflow is sticky.
module gemm_kernel_flow_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 64,
    parameter int CNT_W     = 8,
    parameter int RSP_W     = 257,
    parameter int RSP_DEPTH = 16,
    parameter int AF_MARGIN = 4
) (
    input  logic                   kernel_clk,
    input  logic                   rst,
    gemm_kernel_flow_ctrl_if.slave bus
);
    localparam int AW = $clog2(RSP_DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0]    FULL_LVL = OW'(RSP_DEPTH);
    localparam logic [OW-1:0]    AF_LVL   = OW'(RSP_DEPTH - AF_MARGIN);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, WAIT_LOADS, WAIT_IDLE, FIRE} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         issued_q [NUM_CH];
    logic [CNT_W-1:0]         issued_d [NUM_CH];
    logic [CNT_W-1:0]         carry    [NUM_CH];
    logic [CNT_W-1:0]         exp_q    [NUM_CH];
    logic [CNT_W-1:0]         exp_d    [NUM_CH];
    logic [NUM_CH-1:0]        ch_rdy, xfer, iss_en_q;
    logic [NUM_CH*DATA_W-1:0] iss_data_q, iss_data_d;
    logic                     all_met, start_rdy, start_out_q;

    // A channel is only held off while a batch is pending and its own quota is met.
    always_comb begin
        all_met = 1'b1;
        ch_rdy  = '0;
        xfer    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_rdy[c] = !rst && !(state_q != IDLE && issued_q[c] >= exp_q[c]);
            xfer[c]   = bus.ch_valid[c] && ch_rdy[c];
            if (issued_q[c] < exp_q[c]) all_met = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        start_rdy = 1'b0;
        case (state_q)
            IDLE: begin
                start_rdy = !rst;
                if (bus.start_valid && start_rdy) begin
                    for (int c = 0; c < NUM_CH; c++) exp_d[c] = bus.start_cnt[c*CNT_W +: CNT_W];
                    state_d = WAIT_LOADS;
                end
            end
            WAIT_LOADS: if (all_met) state_d = WAIT_IDLE;
            WAIT_IDLE:  if (!bus.gemm_busy && iss_en_q == '0) state_d = FIRE;
            FIRE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Loads beyond the batch quota carry over into the next batch.
    always_comb begin
        iss_data_d = iss_data_q;
        for (int c = 0; c < NUM_CH; c++) begin
            carry[c]    = (state_q == FIRE) ? issued_q[c] - exp_q[c] : issued_q[c];
            issued_d[c] = (xfer[c] && carry[c] != CNT_MAX) ? carry[c] + CNT_W'(1) : carry[c];
            if (xfer[c]) iss_data_d[c*DATA_W +: DATA_W] = bus.ch_data[c*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge kernel_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            iss_en_q    <= '0;
            iss_data_q  <= '0;
            start_out_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                issued_q[c] <= '0;
                exp_q[c]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            iss_en_q    <= xfer;
            iss_data_q  <= iss_data_d;
            start_out_q <= (state_d == FIRE);
            for (int c = 0; c < NUM_CH; c++) begin
                issued_q[c] <= issued_d[c];
                exp_q[c]    <= exp_d[c];
            end
        end
    end

    logic [RSP_W-1:0] mem_q [RSP_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]    occ_q, occ_d;
    logic             push, pop, full, af_q, ovf_q;

    assign full = (occ_q == FULL_LVL);
    assign pop  = (occ_q != '0) && bus.rsp_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = bus.rsp_in_valid && (!full || pop);

    always_comb begin
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge kernel_clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.rsp_in_data;
    end

    always_ff @(posedge kernel_clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            occ_q <= occ_d;
            af_q  <= (occ_d >= AF_LVL);
            if (bus.rsp_in_valid && full && !pop) ovf_q <= 1'b1;
        end
    end

    logic busy_prev_q, nb_prev_q, done_q, nb_pulse_q;

    always_ff @(posedge kernel_clk) begin
        if (rst) begin
            busy_prev_q <= 1'b0;
            nb_prev_q   <= 1'b0;
            done_q      <= 1'b0;
            nb_pulse_q  <= 1'b0;
        end else begin
            busy_prev_q <= bus.gemm_busy;
            nb_prev_q   <= bus.gemm_next_block;
            done_q      <= busy_prev_q && !bus.gemm_busy;
            nb_pulse_q  <= !nb_prev_q && bus.gemm_next_block;
        end
    end

    assign bus.ch_ready         = ch_rdy;
    assign bus.iss_en           = iss_en_q;
    assign bus.iss_data         = iss_data_q;
    assign bus.start_ready      = start_rdy;
    assign bus.start_out        = start_out_q;
    assign bus.rsp_valid        = (occ_q != '0);
    assign bus.rsp_data         = mem_q[rd_ptr_q];
    assign bus.rsp_almost_full  = af_q;
    assign bus.rsp_overflow     = ovf_q;
    assign bus.done_pulse       = done_q;
    assign bus.next_block_pulse = nb_pulse_q;
endmodule

// File: tb/tb_gemm_kernel_flow_ctrl.sv
// Randomized bench for gemm_kernel_flow_ctrl against a batch/queue reference model.
module tb_gemm_kernel_flow_ctrl;
    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 64;
    localparam int CNT_W     = 8;
    localparam int RSP_W     = 257;
    localparam int RSP_DEPTH = 16;
    localparam int AF_MARGIN = 4;

    logic kernel_clk = 1'b0;
    logic rst        = 1'b1;
    int   errors     = 0;
    int   checks     = 0;

    gemm_kernel_flow_ctrl_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .RSP_W(RSP_W)) bus ();

    gemm_kernel_flow_ctrl #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W),
        .RSP_W(RSP_W), .RSP_DEPTH(RSP_DEPTH), .AF_MARGIN(AF_MARGIN)
    ) dut (
        .kernel_clk(kernel_clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 kernel_clk = ~kernel_clk;

    // Reference model: loads issued per channel, quota of the pending batch, response queue.
    int               m_issued [NUM_CH];
    int               m_exp    [NUM_CH];
    bit               m_pending;
    logic [RSP_W-1:0] rsp_q [$];

    task automatic tick();
        @(posedge kernel_clk);
        #1;
    endtask

    function automatic bit loads_met();
        for (int c = 0; c < NUM_CH; c++) if (m_issued[c] < m_exp[c]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [RSP_W-1:0] rnd_rsp();
        logic [RSP_W-1:0] v = '0;
        for (int i = 0; i < 9; i++) v = {v[RSP_W-33:0], 32'($urandom)};
        return v;
    endfunction

    task automatic clear_inputs();
        bus.ch_valid        = '0;
        bus.ch_data         = '0;
        bus.start_valid     = 1'b0;
        bus.start_cnt       = '0;
        bus.gemm_busy       = 1'b0;
        bus.gemm_next_block = 1'b0;
        bus.rsp_in_valid    = 1'b0;
        bus.rsp_in_data     = '0;
        bus.rsp_ready       = 1'b0;
    endtask

    task automatic clear_model();
        for (int c = 0; c < NUM_CH; c++) begin
            m_issued[c] = 0;
            m_exp[c]    = 0;
        end
        m_pending = 1'b0;
        rsp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        clear_model();
        #1;
    endtask

    // One cycle of channel traffic with random payloads; ready, issue and fence checked against the model.
    task automatic chan_cycle(input logic [NUM_CH-1:0] vld);
        logic [NUM_CH-1:0]        e_rdy, e_xfer;
        logic [NUM_CH*DATA_W-1:0] pay;
        bit                       met_before;
        for (int c = 0; c < NUM_CH; c++) begin
            pay[c*DATA_W +: DATA_W] = {32'($urandom), 32'($urandom)};
            e_rdy[c] = !(m_pending && m_issued[c] >= m_exp[c]);
        end
        e_xfer     = vld & e_rdy;
        met_before = loads_met();
        bus.ch_valid = vld;
        bus.ch_data  = pay;
        checks++;
        if (bus.ch_ready !== e_rdy) begin
            errors++;
            $display("FAIL ch_ready: got %b want %b", bus.ch_ready, e_rdy);
        end
        tick();
        bus.ch_valid = '0;
        checks++;
        if (bus.iss_en !== e_xfer) begin
            errors++;
            $display("FAIL iss_en: got %b want %b", bus.iss_en, e_xfer);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (e_xfer[c]) begin
                checks++;
                if (bus.iss_data[c*DATA_W +: DATA_W] !== pay[c*DATA_W +: DATA_W]) begin
                    errors++;
                    $display("FAIL iss_data ch%0d: got %h want %h", c,
                             bus.iss_data[c*DATA_W +: DATA_W], pay[c*DATA_W +: DATA_W]);
                end
            end
        end
        if (m_pending && !met_before) begin
            checks++;
            if (bus.start_out !== 1'b0) begin
                errors++;
                $display("FAIL start_before_loads: got %b want 0", bus.start_out);
            end
        end
        for (int c = 0; c < NUM_CH; c++)
            if (e_xfer[c] && m_issued[c] < (1 << CNT_W) - 1) m_issued[c]++;
    endtask

    task automatic start_batch(input logic [NUM_CH*CNT_W-1:0] cnt);
        bus.start_cnt   = cnt;
        bus.start_valid = 1'b1;
        checks++;
        if (bus.start_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready: got %b want 1", bus.start_ready);
        end
        tick();
        bus.start_valid = 1'b0;
        m_pending = 1'b1;
        for (int c = 0; c < NUM_CH; c++) m_exp[c] = int'(cnt[c*CNT_W +: CNT_W]);
    endtask

    // Idle the channels for a window, count start pulses and note ready in the cycle after a pulse.
    task automatic wait_fire(input int bound, output int pulses, output logic [NUM_CH-1:0] rdy_after);
        bit prev = 1'b0;
        pulses    = 0;
        rdy_after = '0;
        bus.ch_valid = '0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (prev) rdy_after = bus.ch_ready;
            prev = (bus.start_out === 1'b1);
            if (prev) pulses++;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            m_issued[c] -= m_exp[c];
            m_exp[c]     = 0;
        end
        m_pending = 1'b0;
    endtask

    task automatic drain_check(input string name, input int expect_n);
        int n = 0;
        bus.rsp_in_valid = 1'b0;
        bus.rsp_ready    = 1'b1;
        while (bus.rsp_valid === 1'b1 && n < RSP_DEPTH + 4) begin
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_extra_word: got %h want none", name, bus.rsp_data);
                break;
            end
            checks++;
            if (bus.rsp_data !== rsp_q[0]) begin
                errors++;
                $display("FAIL %s_order word%0d: got %h want %h", name, n, bus.rsp_data, rsp_q[0]);
            end
            void'(rsp_q.pop_front());
            tick();
            n++;
        end
        bus.rsp_ready = 1'b0;
        checks++;
        if (n !== expect_n) begin
            errors++;
            $display("FAIL %s_count: got %0d want %0d", name, n, expect_n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.ch_valid = '1;
        tick();
        tick();
        checks++;
        if (bus.ch_ready !== 4'b0000 || bus.start_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready: got ch=%b st=%b want 0000/0", bus.ch_ready, bus.start_ready);
        end
        checks++;
        if ({bus.iss_en, bus.start_out, bus.rsp_valid, bus.rsp_overflow, bus.rsp_almost_full,
             bus.done_pulse, bus.next_block_pulse} !== 11'b0) begin
            errors++;
            $display("FAIL rst_outputs: got iss=%b so=%b rv=%b ov=%b af=%b dp=%b nb=%b want 0",
                     bus.iss_en, bus.start_out, bus.rsp_valid, bus.rsp_overflow,
                     bus.rsp_almost_full, bus.done_pulse, bus.next_block_pulse);
        end
        bus.ch_valid = '0;
        rst = 1'b0;
        clear_model();
        #1;
        checks++;
        if (bus.ch_ready !== 4'b1111 || bus.start_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: got ch=%b st=%b want 1111/1", bus.ch_ready, bus.start_ready);
        end
    endtask

    task automatic test_single_transfer();
        do_reset();
        bus.ch_valid = 4'b0001;
        bus.ch_data  = '0;
        bus.ch_data[DATA_W-1:0] = 64'h0123;
        #1;
        checks++;
        if (bus.iss_en !== 4'b0000) begin
            errors++;
            $display("FAIL iss_early: got %b want 0000", bus.iss_en);
        end
        tick();
        bus.ch_valid = '0;
        checks++;
        if (bus.iss_en !== 4'b0001 || bus.iss_data[DATA_W-1:0] !== 64'h0123) begin
            errors++;
            $display("FAIL single_issue: got en=%b data=%h want 0001/0123", bus.iss_en, bus.iss_data[DATA_W-1:0]);
        end
        tick();
        checks++;
        if (bus.iss_en !== 4'b0000) begin
            errors++;
            $display("FAIL single_one_cycle: got %b want 0000", bus.iss_en);
        end
    endtask

    task automatic test_fence();
        int                pulses;
        int                guard = 0;
        logic [NUM_CH-1:0] ra;
        do_reset();
        start_batch({8'd0, 8'd0, 8'd2, 8'd3});
        while (!loads_met() && guard < 100) begin
            chan_cycle(NUM_CH'($urandom));
            guard++;
        end
        checks++;
        if (!loads_met()) begin
            errors++;
            $display("FAIL fence_loads: got A=%0d B=%0d want 3/2", m_issued[0], m_issued[1]);
        end
        wait_fire(12, pulses, ra);
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL fence_pulses: got %0d want 1", pulses);
        end
        checks++;
        if (ra !== 4'b1111) begin
            errors++;
            $display("FAIL fence_ready_after: got %b want 1111", ra);
        end
    endtask

    task automatic test_busy_gating();
        do_reset();
        bus.gemm_busy = 1'b1;
        start_batch({8'd0, 8'd0, 8'd0, 8'd1});
        chan_cycle(4'b0001);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.start_out !== 1'b0) begin
                errors++;
                $display("FAIL busy_gate cycle%0d: got %b want 0", i, bus.start_out);
            end
        end
        bus.gemm_busy = 1'b0;
        tick();
        checks++;
        if (bus.start_out !== 1'b1 || bus.done_pulse !== 1'b1) begin
            errors++;
            $display("FAIL busy_fall: got so=%b dp=%b want 1/1", bus.start_out, bus.done_pulse);
        end
        tick();
        checks++;
        if (bus.start_out !== 1'b0 || bus.done_pulse !== 1'b0) begin
            errors++;
            $display("FAIL busy_fall_once: got so=%b dp=%b want 0/0", bus.start_out, bus.done_pulse);
        end
        m_issued[0] -= m_exp[0];
        m_exp[0]  = 0;
        m_pending = 1'b0;
        bus.gemm_next_block = 1'b1;
        tick();
        checks++;
        if (bus.next_block_pulse !== 1'b1) begin
            errors++;
            $display("FAIL nb_rise: got %b want 1", bus.next_block_pulse);
        end
        tick();
        checks++;
        if (bus.next_block_pulse !== 1'b0) begin
            errors++;
            $display("FAIL nb_level: got %b want 0", bus.next_block_pulse);
        end
        bus.gemm_next_block = 1'b0;
        tick();
        checks++;
        if (bus.next_block_pulse !== 1'b0 || bus.done_pulse !== 1'b0) begin
            errors++;
            $display("FAIL nb_fall: got nb=%b dp=%b want 0/0", bus.next_block_pulse, bus.done_pulse);
        end
    endtask

    task automatic test_excess_carry();
        int                pulses;
        logic [NUM_CH-1:0] ra;
        do_reset();
        repeat (5) chan_cycle(4'b0001);
        start_batch({8'd0, 8'd0, 8'd0, 8'd3});
        wait_fire(12, pulses, ra);
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL carry_first: got %0d pulses want 1", pulses);
        end
        start_batch({8'd0, 8'd0, 8'd0, 8'd2});
        wait_fire(12, pulses, ra);
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL carry_second: got %0d pulses want 1", pulses);
        end
        // With the carry consumed, a quota of one must leave channel A ready.
        start_batch({8'd0, 8'd0, 8'd0, 8'd1});
        chan_cycle(4'b0000);
        chan_cycle(4'b0001);
        wait_fire(12, pulses, ra);
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL carry_third: got %0d pulses want 1", pulses);
        end
    endtask

    task automatic test_rsp_overflow();
        logic [RSP_W-1:0] w;
        bit               m_ovf = 1'b0;
        do_reset();
        for (int i = 1; i <= RSP_DEPTH + 1; i++) begin
            w = rnd_rsp();
            bus.rsp_in_valid = 1'b1;
            bus.rsp_in_data  = w;
            tick();
            if (rsp_q.size() < RSP_DEPTH) rsp_q.push_back(w);
            else m_ovf = 1'b1;
            checks++;
            if (bus.rsp_almost_full !== (rsp_q.size() >= RSP_DEPTH - AF_MARGIN)) begin
                errors++;
                $display("FAIL af push%0d: got %b want %b", i, bus.rsp_almost_full,
                         rsp_q.size() >= RSP_DEPTH - AF_MARGIN);
            end
            checks++;
            if (bus.rsp_overflow !== m_ovf || bus.rsp_valid !== 1'b1) begin
                errors++;
                $display("FAIL ovf push%0d: got ov=%b rv=%b want %b/1", i, bus.rsp_overflow, bus.rsp_valid, m_ovf);
            end
        end
        drain_check("ovf_drain", RSP_DEPTH);
        checks++;
        if (bus.rsp_overflow !== 1'b1 || bus.rsp_almost_full !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky: got ov=%b af=%b want 1/0", bus.rsp_overflow, bus.rsp_almost_full);
        end
        do_reset();
        checks++;
        if (bus.rsp_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_reset: got %b want 0", bus.rsp_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [RSP_W-1:0] w;
        do_reset();
        for (int i = 0; i < RSP_DEPTH; i++) begin
            w = rnd_rsp();
            bus.rsp_in_valid = 1'b1;
            bus.rsp_in_data  = w;
            tick();
            rsp_q.push_back(w);
        end
        for (int i = 0; i < 4; i++) begin
            w = rnd_rsp();
            bus.rsp_in_data = w;
            bus.rsp_ready   = 1'b1;
            checks++;
            if (bus.rsp_data !== rsp_q[0]) begin
                errors++;
                $display("FAIL pp_head%0d: got %h want %h", i, bus.rsp_data, rsp_q[0]);
            end
            tick();
            void'(rsp_q.pop_front());
            rsp_q.push_back(w);
            checks++;
            if (bus.rsp_overflow !== 1'b0 || bus.rsp_almost_full !== 1'b1) begin
                errors++;
                $display("FAIL pp_flags%0d: got ov=%b af=%b want 0/1", i, bus.rsp_overflow, bus.rsp_almost_full);
            end
        end
        drain_check("pp_drain", RSP_DEPTH);
    endtask

    task automatic test_reset_mid_batch();
        int                pulses;
        logic [NUM_CH-1:0] ra;
        do_reset();
        start_batch({8'd0, 8'd0, 8'd1, 8'd3});
        chan_cycle(4'b0001);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.ch_ready !== 4'b0000 || bus.start_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready: got ch=%b st=%b want 0000/0", bus.ch_ready, bus.start_ready);
        end
        tick();
        rst = 1'b0;
        clear_model();
        #1;
        checks++;
        if (bus.ch_ready !== 4'b1111 || bus.start_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_idle: got ch=%b st=%b want 1111/1", bus.ch_ready, bus.start_ready);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.start_out !== 1'b0) begin
                errors++;
                $display("FAIL midrst_no_start cycle%0d: got %b want 0", i, bus.start_out);
            end
        end
        start_batch({8'd0, 8'd0, 8'd0, 8'd1});
        chan_cycle(4'b0000);
        chan_cycle(4'b0001);
        wait_fire(12, pulses, ra);
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL midrst_fire: got %0d pulses want 1", pulses);
        end
    endtask

    task automatic test_random_batches();
        int                      pulses;
        int                      guard;
        logic [NUM_CH-1:0]       ra;
        logic [NUM_CH*CNT_W-1:0] cnt;
        do_reset();
        for (int b = 0; b < 6; b++) begin
            repeat ($urandom_range(0, 3)) chan_cycle(NUM_CH'($urandom));
            for (int c = 0; c < NUM_CH; c++) cnt[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 4));
            start_batch(cnt);
            guard = 0;
            while (!loads_met() && guard < 200) begin
                chan_cycle(NUM_CH'($urandom));
                guard++;
            end
            wait_fire(12, pulses, ra);
            checks++;
            if (pulses !== 1 || ra !== 4'b1111) begin
                errors++;
                $display("FAIL rand_batch%0d: got pulses=%0d rdy=%b want 1/1111", b, pulses, ra);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_transfer();
        test_fence();
        test_busy_gating();
        test_excess_carry();
        test_rsp_overflow();
        test_full_push_pop();
        test_reset_mid_batch();
        test_random_batches();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
